// File: rtl/trace_request_queue.sv
// Trace request queue between a quad's execution lanes and the ray tracer.
// Per-lane requests are packed into a FIFO in ascending lane order and issued
// to the tracer one per cycle. Tagged responses are routed back to their lane
// as a held result plus a one-cycle finished pulse.
module trace_request_queue #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 8,
  parameter int RAY_W    = 192,
  parameter int RESULT_W = 64,
  parameter int TAG_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES-1:0]    request_trace,
  input  logic [RAY_W-1:0]    ray_in [LANES],
  output logic                is_trace_queue_full,
  output logic [LANES-1:0]    lane_busy,
  output logic                trace_req_valid,
  output logic [RAY_W-1:0]    trace_req_ray,
  output logic [TAG_W-1:0]    trace_req_tag,
  input  logic                trace_req_ready,
  input  logic                trace_resp_valid,
  input  logic [TAG_W-1:0]    trace_resp_tag,
  input  logic [RESULT_W-1:0] trace_resp_data,
  output logic [RESULT_W-1:0] trace_results [LANES],
  output logic [LANES-1:0]    async_request_finished,
  output logic                protocol_error
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W+RAY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W-1:0]       wr_idx [LANES];
  logic [CNT_W-1:0]       count, count_nxt, push_cnt;
  logic                   req_bad, push_en, pop, resp_hit, resp_bad;
  logic [LANES-1:0]       busy_nxt, fin_nxt;

  // Head of the FIFO is presented directly from storage; the tracer sees it
  // stable for as long as valid is held without ready.
  assign {trace_req_tag, trace_req_ray} = mem[rd_ptr];

  // Slot assignment, request legality, response routing and next count.
  always_comb begin
    push_cnt = '0;
    req_bad  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      wr_idx[l] = wr_ptr + push_cnt[PTR_W-1:0];
      if (request_trace[l]) begin
        push_cnt = push_cnt + CNT_W'(1);
        // A busy lane may only re-request when its response lands this cycle.
        if (lane_busy[l] && !(trace_resp_valid && (trace_resp_tag == TAG_W'(l))))
          req_bad = 1'b1;
      end
    end
    if ((|request_trace) && is_trace_queue_full)
      req_bad = 1'b1;
    push_en = (|request_trace) && !req_bad;
    pop     = trace_req_valid && trace_req_ready;

    resp_hit = trace_resp_valid && (int'(trace_resp_tag) < LANES) && lane_busy[trace_resp_tag];
    resp_bad = trace_resp_valid && !resp_hit;

    busy_nxt = lane_busy;
    fin_nxt  = '0;
    if (resp_hit) begin
      busy_nxt[trace_resp_tag] = 1'b0;
      fin_nxt[trace_resp_tag]  = 1'b1;
    end
    if (push_en)
      busy_nxt = busy_nxt | request_trace;

    count_nxt = count + (push_en ? push_cnt : '0) - CNT_W'(pop);
  end

  // Control state: pointers, occupancy, lane flags, results and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      count                  <= '0;
      trace_req_valid        <= 1'b0;
      is_trace_queue_full    <= 1'b0;
      lane_busy              <= '0;
      async_request_finished <= '0;
      protocol_error         <= 1'b0;
      for (int l = 0; l < LANES; l++)
        trace_results[l] <= '0;
    end else begin
      if (push_en)
        wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count                  <= count_nxt;
      trace_req_valid        <= (count_nxt != '0);
      // Full means a whole quad's worth of requests might not fit.
      is_trace_queue_full    <= (CNT_W'(DEPTH) - count_nxt) < CNT_W'(LANES);
      lane_busy              <= busy_nxt;
      async_request_finished <= fin_nxt;
      protocol_error         <= protocol_error | req_bad | resp_bad;
      if (resp_hit)
        trace_results[trace_resp_tag] <= trace_resp_data;
    end
  end

  // Payload storage; no reset needed since valid gates every read.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (push_en && request_trace[l])
        mem[wr_idx[l]] <= {TAG_W'(l), ray_in[l]};
    end
  end

endmodule
